store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of pending store entries; SHALL be a power of two, at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 st_valid  input  1  store request from the execute/memory stage.
REQ-005 st_ready  output  1  buffer accepts a store this cycle.
REQ-006 st_addr  input  32  store byte address.
REQ-007 st_wdata  input  32  store data, already lane-aligned.
REQ-008 st_wmask  input  4  byte write mask from the write-mask generator.
REQ-009 st_err  output  1  one-cycle pulse: an accepted store had a zero mask (misaligned).
REQ-010 mem_req  output  1  write request to data memory.
REQ-011 mem_gnt  input  1  memory accepts the request this cycle.
REQ-012 mem_addr  output  32  word-aligned write address.
REQ-013 mem_wdata  output  32  write data.
REQ-014 mem_wmask  output  4  byte enables.
REQ-015 ld_addr  input  32  address of the load currently in the memory stage.
REQ-016 ld_hazard  output  1  the load must stall until the buffer no longer blocks it.
REQ-017 empty  output  1  no pending entries.

Function
REQ-018 A store is accepted when st_valid && st_ready; st_ready SHALL equal !full, where full means count == DEPTH.
REQ-019 An accepted store with st_wmask != 0 SHALL be written at wr_ptr as {st_addr[31:2],2'b00}, st_wdata, st_wmask; wr_ptr SHALL increment modulo DEPTH.
REQ-020 An accepted store with st_wmask == 0 SHALL NOT be enqueued; st_err SHALL be 1 in the following cycle only.
REQ-021 mem_req SHALL equal !empty; mem_addr, mem_wdata and mem_wmask SHALL be driven from the entry at rd_ptr.
REQ-022 On mem_req && mem_gnt the head entry SHALL retire; rd_ptr SHALL increment modulo DEPTH.
REQ-023 Minimum latency from acceptance to mem_req is 1 cycle; the buffer SHALL NOT bypass combinationally.
REQ-024 Entries SHALL retire in acceptance order.
REQ-025 Head outputs SHALL be held stable while mem_req && !mem_gnt.
REQ-026 Simultaneous enqueue and retire SHALL leave count unchanged; when full, st_ready stays 0 even if a retire occurs that cycle.
REQ-027 count SHALL track 0..DEPTH; both pointers SHALL wrap from DEPTH-1 to 0.
REQ-028 An enqueue in the same cycle as a retire from empty is impossible; when empty, mem_req = 0 and mem_gnt SHALL be ignored.

Reset
REQ-029 On rst: wr_ptr, rd_ptr and count SHALL be 0, and st_err SHALL be 0; this gives empty=1, st_ready=1, mem_req=0, mem_addr/mem_wdata/mem_wmask=0, ld_hazard=0.
REQ-030 Reset mid-drain SHALL discard all pending entries with no further mem_req.

Configuration
REQ-031 Macro STORE_BUF_ADDR_MATCH_EN.
- Defined: ld_hazard = 1 iff a valid entry's word address equals ld_addr[31:2].
- Undefined: ld_hazard = !empty, a conservative stall.

Structure
REQ-032 Entry struct (addr, wdata, wmask) and the width constants SHALL live in the shared package/defines alongside the MEM_* bus widths.
REQ-033 The address comparator SHALL be sub-module store_buffer_match, instantiated only under STORE_BUF_ADDR_MATCH_EN.

Verification
REQ-034 Reset, then st_valid with st_addr=0x1003, wdata=0xAA000000, wmask=4'b1000 -> next cycle mem_req=1, mem_addr=0x1000, mem_wmask=4'b1000.
REQ-035 Four stores with mem_gnt=0 -> st_ready=0 after the 4th; a fifth st_valid is not accepted; then mem_gnt=1 -> four retires in order over 4 cycles.
REQ-036 Store with wmask=4'b0000 -> st_err pulse for 1 cycle, empty stays 1, no mem_req.
REQ-037 Count=2, enqueue and grant in the same cycle -> count stays 2, order preserved.
REQ-038 With the macro, pending store at 0x2000 and ld_addr=0x2002 -> ld_hazard=1; with ld_addr=0x2004 -> ld_hazard=0. Without the macro -> ld_hazard=1 in both cases.
REQ-039 rst asserted with 3 pending entries and mem_gnt=0 -> immediately empty=1 and mem_req=0.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared widths and entry type for the store buffer
package store_buffer_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_MASK_W = MEM_DATA_W / 8;

    localparam int ADDR_W = MEM_ADDR_W;
    localparam int DATA_W = MEM_DATA_W;
    localparam int MASK_W = MEM_MASK_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } sb_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/store_buffer_match.sv
// rtl/store_buffer_match.sv - load/store word-address comparator (used with STORE_BUF_ADDR_MATCH_EN)
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]  valid,
    input  logic [ADDR_W-1:0] addrs [DEPTH],
    input  logic [ADDR_W-1:0] ld_word_addr,
    output logic              hit
);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (addrs[i] == ld_word_addr)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store buffer; macro STORE_BUF_ADDR_MATCH_EN selects precise load hazard
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [ADDR_W-1:0]     st_addr,
    input  logic [DATA_W-1:0]     st_wdata,
    input  logic [MASK_W-1:0]     st_wmask,
    output logic                  st_err,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    output logic [MEM_MASK_W-1:0] mem_wmask,
    input  logic [ADDR_W-1:0]     ld_addr,
    output logic                  ld_hazard,
    output logic                  empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    sb_entry_t     entries [DEPTH];
    sb_entry_t     head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          accept;
    logic          enq;
    logic          deq;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign st_ready = !full;
    assign accept   = st_valid && st_ready;
    assign enq      = accept && (st_wmask != '0);
    assign mem_req  = !empty;
    assign deq      = mem_req && mem_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            st_err <= 1'b0;
        end else begin
            st_err <= accept && (st_wmask == '0);
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries[wr_ptr] <= '{addr: word_align(st_addr), wdata: st_wdata, wmask: st_wmask};
        end
    end

    // Stale slot contents are masked so an empty buffer presents an all-zero bus.
    assign head      = entries[rd_ptr];
    assign mem_addr  = empty ? '0 : head.addr;
    assign mem_wdata = empty ? '0 : head.wdata;
    assign mem_wmask = empty ? '0 : head.wmask;

`ifdef STORE_BUF_ADDR_MATCH_EN
    logic [DEPTH-1:0]  slot_valid;
    logic [ADDR_W-1:0] slot_addr [DEPTH];
    logic [PW-1:0]     offs;
    logic              unused_bits;

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        slot_valid = '0;
        offs       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs          = PW'(i) - rd_ptr;
            slot_valid[i] = ({1'b0, offs} < count);
            slot_addr[i]  = entries[i].addr;
        end
    end

    store_buffer_match #(.DEPTH(DEPTH)) u_match (
        .valid        (slot_valid),
        .addrs        (slot_addr),
        .ld_word_addr (word_align(ld_addr)),
        .hit          (ld_hazard)
    );

    assign unused_bits = ^{st_addr[1:0], ld_addr[1:0]};
`else
    logic unused_bits;

    assign ld_hazard   = !empty;
    assign unused_bits = ^{st_addr[1:0], ld_addr};
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer with a queue-based reference model
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_wdata = '0;
    logic [3:0]  st_wmask = '0;
    logic        st_err;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] ld_addr = '0;
    logic        ld_hazard;
    logic        empty;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } ent_t;

    ent_t mq[$];
    ent_t sb_q[$];
    bit   err_exp = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_wdata  (st_wdata),
        .st_wmask  (st_wmask),
        .st_err    (st_err),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit hazard_model();
`ifdef STORE_BUF_ADDR_MATCH_EN
        foreach (mq[i]) begin
            if (mq[i].addr[31:2] == ld_addr[31:2]) return 1'b1;
        end
        return 1'b0;
`else
        return mq.size() != 0;
`endif
    endfunction

    // Reference model: FIFO of word-aligned stores, capacity DEPTH.
    always @(posedge clk or posedge rst) begin : model
        bit   acc;
        bit   ret;
        ent_t e;
        if (rst) begin
            mq.delete();
            sb_q.delete();
            err_exp = 1'b0;
        end else begin
            acc = st_valid && (mq.size() < DEPTH);
            ret = (mq.size() != 0) && mem_gnt;
            if (ret) void'(mq.pop_front());
            err_exp = acc && (st_wmask == 4'b0000);
            if (acc && st_wmask != 4'b0000) begin
                e.addr  = st_addr & 32'hFFFF_FFFC;
                e.wdata = st_wdata;
                e.wmask = st_wmask;
                mq.push_back(e);
                sb_q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("empty", empty, mq.size() == 0);
            chk("st_ready", st_ready, mq.size() < DEPTH);
            chk("mem_req", mem_req, mq.size() != 0);
            chk("st_err", st_err, err_exp);
            chk("ld_hazard", ld_hazard, hazard_model());
            if (mem_req) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    chk("mem_addr", mem_addr, sb_q[0].addr);
                    chk("mem_wdata", mem_wdata, sb_q[0].wdata);
                    chk("mem_wmask", mem_wmask, sb_q[0].wmask);
                    if (mem_gnt) void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        st_valid = 1'b1;
        st_addr  = a;
        st_wdata = d;
        st_wmask = m;
        cyc();
        st_valid = 1'b0;
    endtask

    task automatic drain();
        st_valid = 1'b0;
        mem_gnt  = 1'b1;
        repeat (DEPTH + 1) cyc();
        mem_gnt = 1'b0;
        chk("drained", empty, 1'b1);
    endtask

    initial begin
        repeat (2) cyc();
        chk("rst_empty", empty, 1'b1);
        chk("rst_ready", st_ready, 1'b1);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_wmask", mem_wmask, 4'h0);
        chk("rst_hazard", ld_hazard, 1'b0);
        chk("rst_err", st_err, 1'b0);
        rst = 1'b0;
        cyc();

        // single store, no combinational bypass, aligned head next cycle
        st_valid = 1'b1;
        st_addr  = 32'h1003;
        st_wdata = 32'hAA00_0000;
        st_wmask = 4'b1000;
        #1;
        chk("no_bypass", mem_req, 1'b0);
        cyc();
        st_valid = 1'b0;
        chk("first_req", mem_req, 1'b1);
        chk("first_addr", mem_addr, 32'h1000);
        chk("first_wmask", mem_wmask, 4'b1000);
        chk("first_wdata", mem_wdata, 32'hAA00_0000);
        drain();

        // fill to capacity, reject a fifth, drain in order
        for (int i = 0; i < DEPTH; i++) put(32'h4000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'hF);
        chk("full_ready", st_ready, 1'b0);
        put(32'h5000, 32'hDEAD_BEEF, 4'hF);
        chk("full_still", st_ready, 1'b0);
        drain();

        // zero mask: error pulse only
        put(32'h3000, 32'h1234_5678, 4'b0000);
        chk("zm_err", st_err, 1'b1);
        chk("zm_empty", empty, 1'b1);
        chk("zm_req", mem_req, 1'b0);
        cyc();
        chk("zm_err_gone", st_err, 1'b0);

        // simultaneous enqueue and retire at count 2
        put(32'h6000, 32'hA0, 4'h1);
        put(32'h6004, 32'hA1, 4'h2);
        mem_gnt = 1'b1;
        put(32'h6008, 32'hA2, 4'h4);
        mem_gnt = 1'b0;
        put(32'h600C, 32'hA3, 4'h8);
        chk("simul_not_full", st_ready, 1'b1);
        put(32'h6010, 32'hA4, 4'h3);
        chk("simul_full", st_ready, 1'b0);
        drain();

        // load hazard
        put(32'h2000, 32'h77, 4'hF);
        ld_addr = 32'h2002;
        #1;
        chk("hz_same_word", ld_hazard, 1'b1);
        ld_addr = 32'h2004;
        #1;
`ifdef STORE_BUF_ADDR_MATCH_EN
        chk("hz_next_word", ld_hazard, 1'b0);
`else
        chk("hz_next_word", ld_hazard, 1'b1);
`endif
        drain();

        // reset mid-drain
        put(32'h7000, 32'h1, 4'hF);
        put(32'h7004, 32'h2, 4'hF);
        put(32'h7008, 32'h3, 4'hF);
        rst = 1'b1;
        #1;
        chk("mid_rst_empty", empty, 1'b1);
        chk("mid_rst_req", mem_req, 1'b0);
        cyc();
        rst = 1'b0;
        mem_gnt = 1'b1;
        cyc();
        chk("post_rst_req", mem_req, 1'b0);
        mem_gnt = 1'b0;

        // randomized traffic
        repeat (400) begin
            st_valid = ($urandom_range(0, 3) != 0);
            st_addr  = 32'h2000 + 32'($urandom_range(0, 31));
            st_wdata = $urandom;
            st_wmask = 4'($urandom_range(0, 15));
            mem_gnt  = $urandom_range(0, 1) == 1;
            ld_addr  = 32'h2000 + 32'($urandom_range(0, 31));
            cyc();
        end
        drain();
        chk("sb_empty_end", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
